// File: rtl/phold_core_multi.sv
// PHOLD core: reads and updates one LP state word per incoming event,
// then emits NEW_EVT follow-on events, each with its own ack handshake.
module phold_core_multi #(
   parameter int TW              = 16,
   parameter int NIDB            = 3,
   parameter int NRB             = 8,
   parameter int NCB             = 2,
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int NEW_EVT         = 2,
   parameter int DELAY_MIN       = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NCB-1:0]             core_id,
   input  logic                       event_valid,
   input  logic [NIDB-1:0]            event_id,
   input  logic [TW-1:0]              event_time,
   input  logic [NRB-1:0]             random_in,
   input  logic [47:0]                addr,
   output logic [TW-1:0]              new_event_time,
   output logic [NIDB-1:0]            new_event_target,
   output logic                       new_event_ready,
   input  logic                       ack,
   output logic                       ready,
   output logic                       causality_err,
   output logic [31:0]                evt_count,
   output logic                       mc_rq_vld,
   output logic [2:0]                 mc_rq_cmd,
   output logic [3:0]                 mc_rq_scmd,
   output logic [47:0]                mc_rq_vadr,
   output logic [1:0]                 mc_rq_size,
   output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
   output logic [63:0]                mc_rq_data,
   output logic                       mc_rq_flush,
   input  logic                       mc_rq_stall,
   input  logic                       mc_rs_vld,
   input  logic [2:0]                 mc_rs_cmd,
   input  logic [3:0]                 mc_rs_scmd,
   input  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
   input  logic [63:0]                mc_rs_data,
   output logic                       mc_rs_stall,
   input  logic                       mem_gnt
);

   localparam logic [2:0] MCAE_CMD_RD8      = 3'd1;
   localparam logic [2:0] MCAE_CMD_WR8      = 3'd2;
   localparam logic [2:0] MCAE_CMD_RD8_DATA = 3'd2;
   localparam logic [2:0] MCAE_CMD_WR_CMP   = 3'd3;
   localparam logic [63:0] TMAX = (64'd1 << TW) - 64'd1;
   localparam logic [2:0] KLAST = 3'(NEW_EVT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_EMIT
   } state_t;

   state_t                     r_state;
   logic [TW-1:0]              r_time;
   logic [2:0]                 r_k;
   logic                       r_ready;
   logic                       r_caus;
   logic [31:0]                r_evt_cnt;
   logic                       r_nev_rdy;
   logic [TW-1:0]              r_nev_time;
   logic [NIDB-1:0]            r_nev_tgt;
   logic                       r_rq_vld;
   logic [2:0]                 r_rq_cmd;
   logic [47:0]                r_rq_vadr;
   logic [1:0]                 r_rq_size;
   logic [MC_RTNCTL_WIDTH-1:0] r_rq_rtnctl;
   logic [63:0]                r_rq_data;

   logic                       w_rs_mine;
   logic                       w_rd_hit;
   logic                       w_wr_hit;
   logic                       w_rq_acc;
   logic [63:0]                w_sum;
   logic [TW-1:0]              w_new_time;
   logic                       w_unused;

   assign w_rs_mine = mc_rs_vld && (mc_rs_rtnctl[NCB:1] == core_id);
   assign w_rd_hit  = w_rs_mine && (mc_rs_cmd == MCAE_CMD_RD8_DATA);
   assign w_wr_hit  = w_rs_mine && (mc_rs_cmd == MCAE_CMD_WR_CMP);
   assign w_rq_acc  = r_rq_vld && mem_gnt && !mc_rq_stall;

   // Wide sum so the saturation test can never be fooled by a wrap.
   assign w_sum = 64'(r_time) + 64'(DELAY_MIN) + 64'(random_in);
   assign w_new_time = (w_sum > TMAX) ? TMAX[TW-1:0] : w_sum[TW-1:0];

   assign w_unused = ^{mc_rs_scmd, mc_rs_rtnctl, mc_rs_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_time      <= '0;
         r_k         <= '0;
         r_ready     <= 1'b1;
         r_caus      <= 1'b0;
         r_evt_cnt   <= '0;
         r_nev_rdy   <= 1'b0;
         r_nev_time  <= '0;
         r_nev_tgt   <= '0;
         r_rq_vld    <= 1'b0;
         r_rq_cmd    <= '0;
         r_rq_vadr   <= '0;
         r_rq_size   <= '0;
         r_rq_rtnctl <= '0;
         r_rq_data   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (event_valid) begin
                  r_time      <= event_time;
                  r_ready     <= 1'b0;
                  r_rq_vld    <= 1'b1;
                  r_rq_cmd    <= MCAE_CMD_RD8;
                  r_rq_size   <= 2'd3;
                  r_rq_vadr   <= addr + 48'({event_id, 3'b000});
                  r_rq_rtnctl <= MC_RTNCTL_WIDTH'({core_id, 1'b0});
                  r_rq_data   <= '0;
                  r_state     <= S_RD_REQ;
               end
            end
            S_RD_REQ: begin
               if (w_rq_acc) begin
                  r_rq_vld <= 1'b0;
                  r_state  <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (w_rd_hit) begin
                  if (r_time < mc_rs_data[TW-1:0])
                     r_caus <= 1'b1;
                  r_rq_vld    <= 1'b1;
                  r_rq_cmd    <= MCAE_CMD_WR8;
                  r_rq_rtnctl <= MC_RTNCTL_WIDTH'({core_id, 1'b1});
                  r_rq_data   <= {mc_rs_data[63:32] + 32'd1, 32'(r_time)};
                  r_state     <= S_WR_REQ;
               end
            end
            S_WR_REQ: begin
               if (w_rq_acc) begin
                  r_rq_vld <= 1'b0;
                  r_state  <= S_WR_WAIT;
               end
            end
            S_WR_WAIT: begin
               if (w_wr_hit) begin
                  r_evt_cnt <= r_evt_cnt + 32'd1;
                  r_k       <= '0;
                  r_nev_rdy <= 1'b0;
                  r_state   <= S_EMIT;
               end
            end
            S_EMIT: begin
               // Idle cycle with ready low samples the random for event k.
               if (!r_nev_rdy) begin
                  r_nev_time <= w_new_time;
                  r_nev_tgt  <= random_in[NRB-1 -: NIDB];
                  r_nev_rdy  <= 1'b1;
               end else if (ack) begin
                  r_nev_rdy <= 1'b0;
                  if (r_k == KLAST) begin
                     r_ready <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_k <= r_k + 3'd1;
                  end
               end
            end
            default: begin
               r_ready  <= 1'b1;
               r_rq_vld <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign ready            = r_ready;
   assign causality_err    = r_caus;
   assign evt_count        = r_evt_cnt;
   assign new_event_ready  = r_nev_rdy;
   assign new_event_time   = r_nev_time;
   assign new_event_target = r_nev_tgt;
   assign mc_rq_vld        = r_rq_vld;
   assign mc_rq_cmd        = r_rq_cmd;
   assign mc_rq_scmd       = 4'd0;
   assign mc_rq_vadr       = r_rq_vadr;
   assign mc_rq_size       = r_rq_size;
   assign mc_rq_rtnctl     = r_rq_rtnctl;
   assign mc_rq_data       = r_rq_data;
   assign mc_rq_flush      = 1'b0;
   assign mc_rs_stall      = 1'b0;

endmodule
